// File: rtl/dma_service_arbiter.sv
// Four-channel DMA request arbiter and hold-handshake controller.
// Qualifies external and software requests, raises hrq, picks the winning
// channel at hlda grant time and holds the one-hot select for the service.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | no request pending, hrq low
// ST_REQUEST  | hrq high, waiting for hlda; arbitration happens on grant
// ST_SERVICE  | channel selected and frozen until end_of_service or abort
// ST_RELEASE  | service done, hrq low, waiting for the CPU to drop hlda
module dma_service_arbiter #(
   parameter int DREQ_SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       master_clear,
   input  logic [3:0] dreq,
   input  logic       dreq_active_low,
   input  logic       dack_active_high,
   input  logic [3:0] mask,
   input  logic [3:0] software_request,
   input  logic       rotating_priority,
   input  logic       hlda,
   input  logic       end_of_service,
   output logic       hrq,
   output logic [3:0] transfer_register_select,
   output logic [3:0] dack,
   output logic [3:0] clear_software_request,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQUEST = 2'd1,
      ST_SERVICE = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t     state_q, state_n;
   logic       hrq_q, hrq_n;
   logic [3:0] sel_q, sel_n;
   logic [3:0] clr_q, clr_n;
   logic [1:0] top_q, top_n;

   logic [3:0] dreq_pol;
   logic [3:0] sync_dreq;
   logic [3:0] eff_req;
   logic [1:0] top_eff;
   logic [3:0] grant_sel;
   logic [1:0] sel_idx;

   // Polarity is resolved before synchronisation so the flops always carry
   // "asserted" bits and clear to "not requesting".
   assign dreq_pol = dreq_active_low ? ~dreq : dreq;

   generate
      if (DREQ_SYNC_STAGES == 0) begin : g_nosync
         assign sync_dreq = dreq_pol;
      end else begin : g_sync
         logic [3:0] sync_q [DREQ_SYNC_STAGES];

         // Shift the qualified dreq bits through the synchroniser chain.
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < DREQ_SYNC_STAGES; i++) sync_q[i] <= '0;
            end else if (master_clear) begin
               for (int i = 0; i < DREQ_SYNC_STAGES; i++) sync_q[i] <= '0;
            end else begin
               sync_q[0] <= dreq_pol;
               for (int i = 1; i < DREQ_SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
         end

         assign sync_dreq = sync_q[DREQ_SYNC_STAGES-1];
      end
   endgenerate

   assign eff_req = (sync_dreq & ~mask) | software_request;
   assign top_eff = rotating_priority ? top_q : 2'd0;
   assign sel_idx = {sel_q[3] | sel_q[2], sel_q[3] | sel_q[1]};

   // Pick the first requesting channel walking from top upward, modulo 4.
   always_comb begin
      logic [1:0] idx;
      logic       found;
      grant_sel = '0;
      found     = 1'b0;
      idx       = 2'd0;
      for (int i = 0; i < 4; i++) begin
         idx = top_eff + 2'(i);
         if (!found && eff_req[idx]) begin
            grant_sel[idx] = 1'b1;
            found          = 1'b1;
         end
      end
   end

   // Next-state, select, software-clear and priority-pointer decisions.
   always_comb begin
      state_n = state_q;
      sel_n   = sel_q;
      clr_n   = '0;
      top_n   = rotating_priority ? top_q : 2'd0;
      case (state_q)
         ST_IDLE: begin
            if (eff_req != 4'd0) state_n = ST_REQUEST;
         end
         ST_REQUEST: begin
            if (hlda && eff_req != 4'd0) begin
               state_n = ST_SERVICE;
               sel_n   = grant_sel;
            end else if (eff_req == 4'd0) begin
               // A grant arriving with nothing left to serve still has to be
               // handed back cleanly, hence RELEASE rather than IDLE.
               state_n = hlda ? ST_RELEASE : ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (end_of_service) begin
               state_n = ST_RELEASE;
               sel_n   = '0;
               clr_n   = sel_q;
               if (rotating_priority) top_n = sel_idx + 2'd1;
            end else if (!hlda) begin
               state_n = ST_IDLE;
               sel_n   = '0;
            end
         end
         ST_RELEASE: begin
            if (!hlda) state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
            sel_n   = '0;
         end
      endcase
      hrq_n = (state_n == ST_REQUEST) || (state_n == ST_SERVICE);
   end

   // Registered state and outputs; master_clear behaves like a synchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         hrq_q   <= 1'b0;
         sel_q   <= '0;
         clr_q   <= '0;
         top_q   <= 2'd0;
      end else if (master_clear) begin
         state_q <= ST_IDLE;
         hrq_q   <= 1'b0;
         sel_q   <= '0;
         clr_q   <= '0;
         top_q   <= 2'd0;
      end else begin
         state_q <= state_n;
         hrq_q   <= hrq_n;
         sel_q   <= sel_n;
         clr_q   <= clr_n;
         top_q   <= top_n;
      end
   end

   assign hrq                      = hrq_q;
   assign transfer_register_select = sel_q;
   assign dack                     = dack_active_high ? sel_q : ~sel_q;
   assign clear_software_request   = clr_q;
   assign busy                     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dma_service_arbiter.sv
// Bench for dma_service_arbiter: directed scenarios plus randomized services,
// with grants and software-clear pulses checked through a scoreboard.
module tb_dma_service_arbiter;

   localparam int SYNC = 2;

   logic       clock = 1'b0;
   logic       reset;
   logic       master_clear;
   logic [3:0] dreq;
   logic       dreq_active_low;
   logic       dack_active_high;
   logic [3:0] mask;
   logic [3:0] software_request;
   logic       rotating_priority;
   logic       hlda;
   logic       end_of_service;
   logic       hrq;
   logic [3:0] sel;
   logic [3:0] dack;
   logic [3:0] clr;
   logic       busy;

   dma_service_arbiter #(.DREQ_SYNC_STAGES(SYNC)) dut (
      .clock                    (clock),
      .reset                    (reset),
      .master_clear             (master_clear),
      .dreq                     (dreq),
      .dreq_active_low          (dreq_active_low),
      .dack_active_high         (dack_active_high),
      .mask                     (mask),
      .software_request         (software_request),
      .rotating_priority        (rotating_priority),
      .hlda                     (hlda),
      .end_of_service           (end_of_service),
      .hrq                      (hrq),
      .transfer_register_select (sel),
      .dack                     (dack),
      .clear_software_request   (clr),
      .busy                     (busy)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0] exp_grant_q [$];
   logic [3:0] exp_dack_q  [$];
   logic [3:0] exp_clr_q   [$];

   int         model_top = 0;
   logic [3:0] dreq_lv = 4'd0;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_dreq(input logic [3:0] lv);
      dreq_lv = lv;
      dreq    = dreq_active_low ? ~lv : lv;
   endtask

   // Reference arbitration: first asserted channel in order top, top+1, ...
   function automatic logic [3:0] model_grant(input logic [3:0] eff, input bit rot);
      int t;
      t = rot ? model_top : 0;
      for (int i = 0; i < 4; i++) begin
         int c;
         c = (t + i) % 4;
         if (eff[c]) return 4'b0001 << c;
      end
      return 4'b0000;
   endfunction

   function automatic int onehot_index(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return 0;
   endfunction

   // Scoreboard monitor: pops an expectation on each new grant and each clear pulse.
   logic [3:0] sel_prev = 4'd0;
   always @(negedge clock) begin
      if (!reset) begin
         if (sel_prev == 4'd0 && sel != 4'd0) begin
            if (exp_grant_q.size() == 0) chk("unexpected_grant", sel, 4'b0000);
            else begin
               chk("grant_sel", sel, exp_grant_q.pop_front());
               chk("grant_dack", dack, exp_dack_q.pop_front());
            end
         end
         if (clr != 4'd0) begin
            if (exp_clr_q.size() == 0) chk("unexpected_clear", clr, 4'b0000);
            else chk("clear_pulse", clr, exp_clr_q.pop_front());
         end
      end
      sel_prev = sel;
   end

   task automatic wait_hrq(input int exp_lat);
      int c;
      c = 0;
      while (c < 12) begin
         tick();
         c++;
         if (hrq) break;
      end
      chk_int("hrq_latency", hrq ? c : -1, exp_lat);
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      while (busy && c < 12) begin
         tick();
         c++;
      end
      chk("return_idle_busy", {3'b0, busy}, 4'b0000);
   endtask

   // mode 0: normal completion, 1: hlda abort, 2: end_of_service with hlda drop
   task automatic serve(input logic [3:0] d, input logic [3:0] m, input logic [3:0] s,
                        input int mode);
      logic [3:0] g;
      if (!rotating_priority) model_top = 0;
      mask             = m;
      software_request = s;
      set_dreq(d);
      wait_hrq((s != 4'd0) ? 1 : SYNC + 1);
      repeat (3) tick();
      g = model_grant((d & ~m) | s, rotating_priority);
      exp_grant_q.push_back(g);
      exp_dack_q.push_back(dack_active_high ? g : ~g);
      hlda = 1'b1;
      tick();
      chk("sel_after_hlda", sel, g);
      chk("hrq_in_service", {3'b0, hrq}, 4'b0001);
      set_dreq(4'd0);
      software_request = 4'd0;
      mask = 4'($urandom_range(0, 15));
      repeat (3) tick();
      chk("sel_frozen", sel, g);
      case (mode)
         0: begin
            exp_clr_q.push_back(g);
            end_of_service = 1'b1;
            tick();
            end_of_service = 1'b0;
            if (rotating_priority) model_top = (onehot_index(g) + 1) % 4;
            chk("sel_after_eos", sel, 4'd0);
            chk("hrq_after_eos", {3'b0, hrq}, 4'd0);
            repeat (2) tick();
            chk("hrq_release", {3'b0, hrq}, 4'd0);
            hlda = 1'b0;
         end
         1: begin
            hlda = 1'b0;
            tick();
            chk("sel_after_abort", sel, 4'd0);
            chk("hrq_after_abort", {3'b0, hrq}, 4'd0);
         end
         default: begin
            exp_clr_q.push_back(g);
            end_of_service = 1'b1;
            hlda           = 1'b0;
            tick();
            end_of_service = 1'b0;
            if (rotating_priority) model_top = (onehot_index(g) + 1) % 4;
            chk("sel_after_eos_drop", sel, 4'd0);
            chk("hrq_after_eos_drop", {3'b0, hrq}, 4'd0);
         end
      endcase
      wait_idle();
      mask = 4'd0;
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
      $fatal(1);
   end

   initial begin
      logic [3:0] d, m, s;
      reset             = 1'b1;
      master_clear      = 1'b0;
      dreq_active_low   = 1'b0;
      dack_active_high  = 1'b1;
      mask              = 4'd0;
      software_request  = 4'd0;
      rotating_priority = 1'b0;
      hlda              = 1'b0;
      end_of_service    = 1'b0;
      set_dreq(4'd0);
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      tick();
      chk("reset_hrq", {3'b0, hrq}, 4'd0);
      chk("reset_sel", sel, 4'd0);
      chk("reset_dack", dack, 4'd0);
      chk("reset_clr", clr, 4'd0);
      chk("reset_busy", {3'b0, busy}, 4'd0);

      // Fixed priority, ch1 beats ch3.
      serve(4'b1010, 4'd0, 4'd0, 0);

      // Rotating priority sequence.
      rotating_priority = 1'b1;
      serve(4'b0010, 4'd0, 4'd0, 0);
      serve(4'b1111, 4'd0, 4'd0, 0);
      serve(4'b1000, 4'd0, 4'd0, 0);
      serve(4'b1111, 4'd0, 4'd0, 0);

      // Request withdrawn before hlda.
      set_dreq(4'b0001);
      wait_hrq(SYNC + 1);
      set_dreq(4'd0);
      repeat (4) tick();
      chk("hrq_withdrawn", {3'b0, hrq}, 4'd0);
      hlda = 1'b1;
      repeat (4) tick();
      chk("sel_no_request", sel, 4'd0);
      chk("dack_no_request", dack, 4'd0);
      chk("hrq_no_request", {3'b0, hrq}, 4'd0);
      hlda = 1'b0;
      repeat (2) tick();

      // Masked dreq is ignored; software request is not.
      rotating_priority = 1'b0;
      mask = 4'b0001;
      set_dreq(4'b0001);
      repeat (6) tick();
      chk("hrq_masked", {3'b0, hrq}, 4'd0);
      serve(4'b0001, 4'b0001, 4'b0001, 0);

      // Abort on ch2 in rotating mode leaves the pointer alone.
      rotating_priority = 1'b1;
      serve(4'b0100, 4'd0, 4'd0, 1);
      serve(4'b1111, 4'd0, 4'd0, 0);

      // Randomized services.
      for (int k = 0; k < 24; k++) begin
         rotating_priority = 1'($urandom_range(0, 1));
         do begin
            d = 4'($urandom_range(0, 15));
            m = 4'($urandom_range(0, 15));
            s = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
         end while (((d & ~m) | s) == 4'd0);
         serve(d, m, s, int'($urandom_range(0, 2)));
      end

      // Inverted polarities, then master_clear mid-service.
      rotating_priority = 1'b0;
      dreq_active_low   = 1'b1;
      dack_active_high  = 1'b0;
      set_dreq(4'd0);
      tick();
      chk("dack_idle_low", dack, 4'b1111);
      set_dreq(4'b0001);
      wait_hrq(SYNC + 1);
      repeat (3) tick();
      exp_grant_q.push_back(4'b0001);
      exp_dack_q.push_back(4'b1110);
      hlda = 1'b1;
      tick();
      chk("sel_active_low", sel, 4'b0001);
      chk("dack_active_low", dack, 4'b1110);
      repeat (2) tick();
      master_clear = 1'b1;
      set_dreq(4'd0);
      tick();
      master_clear = 1'b0;
      model_top    = 0;
      chk("mclr_dack", dack, 4'b1111);
      chk("mclr_hrq", {3'b0, hrq}, 4'd0);
      chk("mclr_busy", {3'b0, busy}, 4'd0);
      hlda = 1'b0;
      repeat (4) tick();
      chk("mclr_hrq_later", {3'b0, hrq}, 4'd0);

      chk_int("grants_outstanding", exp_grant_q.size(), 0);
      chk_int("clears_outstanding", exp_clr_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dma_service_arbiter.md
Name: dma_service_arbiter

Overview:
- Four-channel DMA request arbiter and hold-handshake controller for the KF8237 core.
- Combines external DREQ, software requests and channel masks, raises HRQ, and picks the winning channel when HLDA is granted.
- Holds the one-hot channel select steady for the whole service, which drives the transfer register select of the address/count register block.
- Supports fixed and rotating priority, and DREQ/DACK polarity control.

Parameters:
DREQ_SYNC_STAGES, 2, number of synchroniser flops on each dreq bit (legal 0..3; 0 = use raw input).

Ports:
clock  input  1  system clock
reset  input  1  reset, asynchronous, active-high
master_clear  input  1  software master clear; synchronous, same effect as reset
dreq  input  4  external DMA requests, one per channel
dreq_active_low  input  1  1: a dreq bit is asserted when low
dack_active_high  input  1  1: dack outputs are active-high
mask  input  4  1 = channel's external dreq ignored
software_request  input  4  request-register bits; never masked, not synchronised
rotating_priority  input  1  0 = fixed priority (ch0 highest), 1 = rotating
hlda  input  1  hold acknowledge from the CPU
end_of_service  input  1  one-cycle pulse from timing control: service of the current channel is finished
hrq  output  1  hold request (registered)
transfer_register_select  output  4  one-hot channel in service, 0 when none (registered)
dack  output  4  DMA acknowledge; polarity applied to transfer_register_select
clear_software_request  output  4  one-cycle pulse clearing the served channel's request bit
busy  output  1  1 in REQUEST, SERVICE or RELEASE

Behaviour:
- Request qualification:
  - Polarity is applied to dreq first, then the result passes through DREQ_SYNC_STAGES flops.
  - eff_req = (sync_dreq & ~mask) | software_request.
- Priority:
  - Pointer `top` (2 bits) names the highest-priority channel; the order is top, top+1, top+2, top+3, modulo 4.
  - Fixed mode: top is forced to 0.
  - Rotating mode: after a normal completion on channel n, top becomes (n+1) mod 4.
- State machine (registered; reset/master_clear -> IDLE):
  - IDLE: if eff_req != 0, go to REQUEST; hrq=1 on the next clock edge.
  - REQUEST: hrq=1.
    - If hlda=1 and eff_req != 0: latch the highest-priority eff_req bit into transfer_register_select and go to SERVICE. Arbitration happens at grant time, not at request time.
    - If eff_req == 0 before hlda: hrq=0, go to IDLE.
    - If hlda=1 and eff_req == 0 in the same cycle: hrq=0, go to RELEASE.
  - SERVICE: select is frozen; changes to dreq, mask and priority are ignored.
    - end_of_service=1 (normal completion): select=0, hrq=0, clear_software_request=old select for one cycle, update top, go to RELEASE.
    - hlda=0 before end_of_service (abort): select=0, hrq=0, top unchanged, no software clear, go to IDLE.
    - If end_of_service and the hlda drop occur in the same cycle, treat it as normal completion.
  - RELEASE: hrq=0. Wait for hlda=0, then go to IDLE. No new hrq is issued while hlda is still high.
- Latency:
  - dreq edge to hrq = DREQ_SYNC_STAGES+1 clocks.
  - software_request to hrq = 1 clock.
  - hlda sampled high to select/dack asserted = 1 clock.
- dack = dack_active_high ? select : ~select, combinational from the select register, so it is glitch-free.
- Reset and master_clear values: hrq=0, select=0, dack=inactive (0000 if active-high, 1111 if active-low), clear_software_request=0, busy=0, top=0, sync flops=0.
- Reset or master_clear mid-service drops hrq and dack on that edge (asynchronously for reset).
- Only one channel is ever selected; select is always zero or one-hot.

Test Plan:
- Fixed priority, dreq=4'b1010 active-high, mask=0, then hlda=1 -> hrq after 3 clocks; select=0010 and dack=0010 one clock after hlda.
- Rotating priority:
  - Serve ch1 to end_of_service, drop hlda, then assert dreq=1111 with hlda -> select=0100 (ch2).
  - Serve ch3, repeat -> select=0001.
- dreq=0001 withdrawn before hlda -> hrq returns to 0; later hlda=1 gives select=0000 and no dack.
- mask=0001, dreq=0001, software_request=0000 -> hrq stays 0.
  - software_request=0001 -> hrq=1 after 1 clock, ch0 served.
  - At end_of_service, clear_software_request=0001 for exactly one cycle.
- hlda dropped during SERVICE on ch2 in rotating mode -> select=0, hrq=0, next arbitration still uses top unchanged.
- dreq_active_low=1, dack_active_high=0, dreq=4'b1110 -> ch0 served, dack=1110. master_clear mid-service -> dack=1111, hrq=0 next clock.
